// File: rtl/regfile_pkg.sv
// Shared types and parameter defaults for the multiport register file.
package regfile_pkg;

    // Sweep/ready states of the array.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    localparam int unsigned RF_DATA_WIDTH      = 32;
    localparam int unsigned RF_ADDR_WIDTH      = 5;
    localparam int unsigned RF_NUM_READ_PORTS  = 2;
    localparam int unsigned RF_NUM_WRITE_PORTS = 1;
    localparam int unsigned RF_BYPASS          = 1;
    localparam int unsigned RF_ZERO_REGISTER   = 1;

endpackage

// File: rtl/regfile_multiport_if.sv
// Read/write bus of the multiport register file.
interface regfile_multiport_if
    import regfile_pkg::*;
#(
    parameter int unsigned DataWidth     = RF_DATA_WIDTH,
    parameter int unsigned AddrWidth     = RF_ADDR_WIDTH,
    parameter int unsigned NumReadPorts  = RF_NUM_READ_PORTS,
    parameter int unsigned NumWritePorts = RF_NUM_WRITE_PORTS
) ();

    logic                                        i_Clear;
    logic [NumReadPorts-1:0][AddrWidth-1:0]      i_RS;
    logic [NumReadPorts-1:0][DataWidth-1:0]      o_DS;
    logic [NumWritePorts-1:0][AddrWidth-1:0]     i_RD;
    logic [NumWritePorts-1:0]                    i_WriteEnable;
    logic [NumWritePorts-1:0][DataWidth-1:0]     i_D;
    logic                                        o_Ready;
    logic                                        o_WriteDropped;

    modport master (
        output i_Clear, i_RS, i_RD, i_WriteEnable, i_D,
        input  o_DS, o_Ready, o_WriteDropped
    );

    modport slave (
        input  i_Clear, i_RS, i_RD, i_WriteEnable, i_D,
        output o_DS, o_Ready, o_WriteDropped
    );

endinterface

// File: rtl/regfile_clear_sequencer.sv
// Clear/ready sequencer: sweeps every entry to zero after reset or a clear request.
module regfile_clear_sequencer
    import regfile_pkg::*;
#(
    parameter int unsigned AddrWidth = RF_ADDR_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    output logic [AddrWidth-1:0] clear_idx_o,
    output logic                 clear_strobe_o,
    output logic                 ready_o
);

    rf_state_e            state_q;
    logic [AddrWidth-1:0] count_q;

    // State and sweep counter; a clear request is only honoured once READY.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= CLEAR;
            count_q <= '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (count_q == '1) begin
                        state_q <= READY;
                        count_q <= '0;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                READY: begin
                    if (clear_i) begin
                        state_q <= CLEAR;
                        count_q <= '0;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                    count_q <= '0;
                end
            endcase
        end
    end

    assign clear_idx_o    = count_q;
    assign clear_strobe_o = (state_q == CLEAR);
    assign ready_o        = (state_q == READY);

endmodule

// File: rtl/regfile_multiport.sv
// Multiport register file with zero-sweep on reset/clear, optional write
// bypass and optional hard-wired zero entry.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int unsigned DataWidth     = RF_DATA_WIDTH,
    parameter int unsigned AddrWidth     = RF_ADDR_WIDTH,
    parameter int unsigned NumReadPorts  = RF_NUM_READ_PORTS,
    parameter int unsigned NumWritePorts = RF_NUM_WRITE_PORTS,
    parameter int unsigned Bypass        = RF_BYPASS,
    parameter int unsigned ZeroRegister  = RF_ZERO_REGISTER
) (
    input logic          i_Clock,
    input logic          i_Reset,
    regfile_multiport_if.slave bus
);

    localparam int unsigned Depth = 1 << AddrWidth;

    logic [DataWidth-1:0]                    mem_q [Depth];
    logic [AddrWidth-1:0]                    clr_idx;
    logic                                    clr_strobe;
    logic                                    ready;
    logic                                    dropped_q;
    logic                                    dropped_d;
    logic [NumReadPorts-1:0][DataWidth-1:0]  rd_data;

    regfile_clear_sequencer #(
        .AddrWidth (AddrWidth)
    ) u_seq (
        .clk_i          (i_Clock),
        .rst_ni         (i_Reset),
        .clear_i        (bus.i_Clear),
        .clear_idx_o    (clr_idx),
        .clear_strobe_o (clr_strobe),
        .ready_o        (ready)
    );

    // Array update: sweep write while clearing, otherwise external writes.
    // Later loop iterations override earlier ones, so the highest port wins.
    always_ff @(posedge i_Clock) begin
        if (clr_strobe) begin
            mem_q[clr_idx] <= '0;
        end else begin
            for (int unsigned p = 0; p < NumWritePorts; p++) begin
                if (bus.i_WriteEnable[p] &&
                    !((ZeroRegister != 0) && (bus.i_RD[p] == '0))) begin
                    mem_q[bus.i_RD[p]] <= bus.i_D[p];
                end
            end
        end
    end

    // Combinational reads with optional forwarding of this cycle's writes.
    always_comb begin
        rd_data = '0;
        for (int unsigned r = 0; r < NumReadPorts; r++) begin
            if (ready) begin
                rd_data[r] = mem_q[bus.i_RS[r]];
                if (Bypass != 0) begin
                    for (int unsigned p = 0; p < NumWritePorts; p++) begin
                        if (bus.i_WriteEnable[p] && (bus.i_RD[p] == bus.i_RS[r])) begin
                            rd_data[r] = bus.i_D[p];
                        end
                    end
                end
                if ((ZeroRegister != 0) && (bus.i_RS[r] == '0)) begin
                    rd_data[r] = '0;
                end
            end
        end
    end

    // A write strobe seen during the sweep is reported one cycle later.
    always_comb begin
        dropped_d = !ready && (|bus.i_WriteEnable);
    end

    // Registered dropped-write pulse.
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            dropped_q <= 1'b0;
        end else begin
            dropped_q <= dropped_d;
        end
    end

    assign bus.o_DS           = rd_data;
    assign bus.o_Ready        = ready;
    assign bus.o_WriteDropped = dropped_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: a 32x32 two-write-port instance with
// bypass and zero register, plus a small 4x8 instance without either.
module tb_regfile_multiport;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    regfile_multiport_if #(
        .DataWidth(32), .AddrWidth(5), .NumReadPorts(2), .NumWritePorts(2)
    ) bus_a ();

    regfile_multiport_if #(
        .DataWidth(8), .AddrWidth(2), .NumReadPorts(1), .NumWritePorts(1)
    ) bus_b ();

    regfile_multiport #(
        .DataWidth(32), .AddrWidth(5), .NumReadPorts(2), .NumWritePorts(2),
        .Bypass(1), .ZeroRegister(1)
    ) dut_a (
        .i_Clock (clk),
        .i_Reset (rst_n),
        .bus     (bus_a)
    );

    regfile_multiport #(
        .DataWidth(8), .AddrWidth(2), .NumReadPorts(1), .NumWritePorts(1),
        .Bypass(0), .ZeroRegister(0)
    ) dut_b (
        .i_Clock (clk),
        .i_Reset (rst_n),
        .bus     (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until dut_a reports ready (bounded), counting cycles and any
    // non-zero read seen on the way.
    task automatic wait_ready(output int n, output int nonzero);
        n = 0;
        nonzero = 0;
        while (!bus_a.o_Ready && n < 100) begin
            if (bus_a.o_DS[0] != '0 || bus_a.o_DS[1] != '0) nonzero++;
            tick();
            n++;
        end
    endtask

    int n;
    int nz;

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        rst_n          = 1'b0;
        bus_a.i_Clear       = 1'b0;
        bus_a.i_RS          = '0;
        bus_a.i_RD          = '0;
        bus_a.i_WriteEnable = '0;
        bus_a.i_D           = '0;
        bus_b.i_Clear       = 1'b0;
        bus_b.i_RS          = '0;
        bus_b.i_RD          = '0;
        bus_b.i_WriteEnable = '0;
        bus_b.i_D           = '0;

        // Reset state.
        repeat (2) tick();
        check_eq("rst_ready", {31'd0, bus_a.o_Ready}, 32'd0);
        check_eq("rst_dropped", {31'd0, bus_a.o_WriteDropped}, 32'd0);

        // Release: ready stays low 32 cycles with reads forced to zero.
        bus_a.i_RS[0] = 5'd3;
        bus_a.i_RS[1] = 5'd31;
        rst_n = 1'b1;
        wait_ready(n, nz);
        check_eq("init_sweep_cycles", n, 32);
        check_eq("init_sweep_nonzero_reads", nz, 0);
        check_eq("init_ready", {31'd0, bus_a.o_Ready}, 32'd1);
        check_eq("init_x3_zero", bus_a.o_DS[0], 32'h0);
        check_eq("b_ready", {31'd0, bus_b.o_Ready}, 32'd1);

        // Writes to x1 and x5, read back the following cycle.
        bus_a.i_RD[0] = 5'd1; bus_a.i_D[0] = 32'hFEEDFACE; bus_a.i_WriteEnable = 2'b01;
        tick();
        bus_a.i_RD[0] = 5'd5; bus_a.i_D[0] = 32'hDEADBEEF;
        tick();
        bus_a.i_WriteEnable = 2'b00;
        bus_a.i_RS[0] = 5'd1; bus_a.i_RS[1] = 5'd5;
        #1;
        check_eq("rd_x1", bus_a.o_DS[0], 32'hFEEDFACE);
        check_eq("rd_x5", bus_a.o_DS[1], 32'hDEADBEEF);

        // Bypass of a same-cycle write to x16.
        bus_a.i_RD[0] = 5'd16; bus_a.i_D[0] = 32'hC0FFEEEE; bus_a.i_WriteEnable = 2'b01;
        bus_a.i_RS[0] = 5'd16;
        #1;
        check_eq("bypass_x16", bus_a.o_DS[0], 32'hC0FFEEEE);
        check_eq("bypass_other_port_x5", bus_a.o_DS[1], 32'hDEADBEEF);
        tick();
        bus_a.i_WriteEnable = 2'b00;
        #1;
        check_eq("stored_x16", bus_a.o_DS[0], 32'hC0FFEEEE);

        // x0 ignores writes and is never forwarded.
        bus_a.i_RD[0] = 5'd0; bus_a.i_D[0] = 32'h12345678; bus_a.i_WriteEnable = 2'b01;
        bus_a.i_RS[0] = 5'd0;
        #1;
        check_eq("x0_bypass_zero", bus_a.o_DS[0], 32'h0);
        tick();
        bus_a.i_WriteEnable = 2'b00;
        #1;
        check_eq("x0_stored_zero", bus_a.o_DS[0], 32'h0);

        // Both write ports target x7: port 1 wins, in bypass and in storage.
        bus_a.i_RD[0] = 5'd7; bus_a.i_D[0] = 32'h11111111;
        bus_a.i_RD[1] = 5'd7; bus_a.i_D[1] = 32'h22222222;
        bus_a.i_WriteEnable = 2'b11;
        bus_a.i_RS[1] = 5'd7;
        #1;
        check_eq("dual_bypass_x7", bus_a.o_DS[1], 32'h22222222);
        tick();
        bus_a.i_WriteEnable = 2'b00;
        #1;
        check_eq("dual_stored_x7", bus_a.o_DS[1], 32'h22222222);

        // Bypass = 0, ZeroRegister = 0: old data in write cycle, new after.
        bus_b.i_RD[0] = 2'd2; bus_b.i_D[0] = 8'hC3; bus_b.i_WriteEnable = 1'b1;
        bus_b.i_RS[0] = 2'd2;
        #1;
        check_eq("b_x2_prewrite", {24'd0, bus_b.o_DS[0]}, 32'h00);
        tick();
        bus_b.i_RD[0] = 2'd0; bus_b.i_D[0] = 8'h5A;
        #1;
        check_eq("b_x2_postwrite", {24'd0, bus_b.o_DS[0]}, 32'hC3);
        tick();
        bus_b.i_WriteEnable = 1'b0;
        bus_b.i_RS[0] = 2'd0;
        #1;
        check_eq("b_x0_writable", {24'd0, bus_b.o_DS[0]}, 32'h5A);

        // Clear pulse in READY; a write during the sweep is dropped.
        bus_a.i_Clear = 1'b1;
        tick();
        bus_a.i_Clear = 1'b0;
        check_eq("clr_ready_low", {31'd0, bus_a.o_Ready}, 32'd0);
        bus_a.i_RD[0] = 5'd3; bus_a.i_D[0] = 32'hAAAA5555; bus_a.i_WriteEnable = 2'b01;
        bus_a.i_RS[0] = 5'd3;
        #1;
        check_eq("clr_read_forced_zero", bus_a.o_DS[0], 32'h0);
        tick();
        bus_a.i_WriteEnable = 2'b00;
        check_eq("clr_dropped_pulse", {31'd0, bus_a.o_WriteDropped}, 32'd1);
        tick();
        check_eq("clr_dropped_clears", {31'd0, bus_a.o_WriteDropped}, 32'd0);
        bus_a.i_RS[1] = 5'd7;
        wait_ready(n, nz);
        check_eq("clr_low_cycles", n + 2, 32);
        #1;
        check_eq("clr_x3_zero", bus_a.o_DS[0], 32'h0);
        check_eq("clr_x7_zero", bus_a.o_DS[1], 32'h0);

        // Reset asserted at sweep counter 10 restarts the full sweep.
        bus_a.i_Clear = 1'b1;
        tick();
        bus_a.i_Clear = 1'b0;
        repeat (9) tick();
        bus_a.i_WriteEnable = 2'b01;
        tick();
        bus_a.i_WriteEnable = 2'b00;
        check_eq("pre_rst_dropped", {31'd0, bus_a.o_WriteDropped}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_ready", {31'd0, bus_a.o_Ready}, 32'd0);
        check_eq("mid_rst_dropped", {31'd0, bus_a.o_WriteDropped}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        wait_ready(n, nz);
        check_eq("restart_sweep_cycles", n, 32);
        check_eq("restart_nonzero_reads", nz, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regfile_multiport.md
REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 SHALL have parameter DataWidth, default 32, meaning bits per register.
REQ-002 SHALL have parameter AddrWidth, default 5, meaning index width; Depth = 2**AddrWidth.
REQ-003 SHALL have parameter NumReadPorts, default 2, meaning independent combinational read ports (1..4).
REQ-004 SHALL have parameter NumWritePorts, default 1, meaning independent write ports (1..2).
REQ-005 SHALL have parameter Bypass, default 1, meaning a same-cycle write is forwarded to matching reads.
REQ-006 SHALL have parameter ZeroRegister, default 1, meaning entry 0 reads 0 and ignores writes.
REQ-007 SHALL have port i_Clock  input  1  meaning the single clock; all state updates on its rising edge.
REQ-008 SHALL have port i_Reset  input  1  meaning reset, asynchronous assert, active-low.
REQ-009 SHALL have port i_Clear  input  1  meaning synchronous request to re-zero the whole array.
REQ-010 SHALL have port i_RS  input  NumReadPorts x AddrWidth  meaning read addresses.
REQ-011 SHALL have port o_DS  output  NumReadPorts x DataWidth  meaning read data.
REQ-012 SHALL have port i_RD  input  NumWritePorts x AddrWidth  meaning write addresses.
REQ-013 SHALL have port i_WriteEnable  input  NumWritePorts  meaning per-port write strobe.
REQ-014 SHALL have port i_D  input  NumWritePorts x DataWidth  meaning write data.
REQ-015 SHALL have port o_Ready  output  1  meaning array cleared and accepting writes.
REQ-016 SHALL have port o_WriteDropped  output  1  meaning registered pulse: a write strobe arrived while not ready.

Function
REQ-017 SHALL implement FSM states CLEAR and READY; reset enters CLEAR with sweep counter 0.
REQ-018 SHALL, in CLEAR, write zero to entry[counter] each cycle and increment counter; at counter == Depth-1 go to READY next cycle (CLEAR lasts exactly Depth cycles).
REQ-019 SHALL, in READY with i_Clear high, go to CLEAR with counter 0 next cycle; writes in that same cycle SHALL still commit.
REQ-020 SHALL ignore i_Clear while in CLEAR (sweep not restarted).
REQ-021 SHALL drive o_Ready = 1 only in READY (combinational from state).
REQ-022 SHALL, in CLEAR, drop all external writes and force every o_DS to 0.
REQ-023 SHALL, in READY, commit i_D[p] to entry i_RD[p] at the rising edge when i_WriteEnable[p] is high.
REQ-024 SHALL resolve two write ports targeting one entry in the same cycle by letting the higher port index win.
REQ-025 SHALL present reads combinationally: o_DS[r] = entry[i_RS[r]] with zero-cycle latency.
REQ-026 SHALL, when Bypass = 1 and READY, return i_D of the highest-indexed enabled write port whose i_RD equals i_RS[r] instead of stored data.
REQ-027 SHALL, when Bypass = 0, return pre-write contents in the write cycle and new contents from the next cycle.
REQ-028 SHALL, when ZeroRegister = 1, return 0 for i_RS[r] == 0, including bypass, and never modify entry 0.
REQ-029 SHALL set o_WriteDropped for one cycle after any cycle in CLEAR with any i_WriteEnable bit high; 0 otherwise.

Reset
REQ-030 SHALL, on i_Reset low, asynchronously set state CLEAR, counter 0, o_WriteDropped 0, o_Ready 0; array contents not reset directly (cleared by sweep).
REQ-031 SHALL, on reset asserted mid-sweep or mid-operation, restart the sweep from entry 0 after release.

Structure
REQ-032 SHALL place the state enum (CLEAR, READY) and parameter defaults in shared package regfile_pkg.
REQ-033 SHALL implement the FSM and counter as sub-module regfile_clear_sequencer, outputting clear index, clear strobe, ready.

Verification
REQ-034 SHALL cover reset release -> o_Ready low for exactly 32 cycles, then high; all o_DS read 0 in between.
REQ-035 SHALL cover write x1=FEEDFACE, x5=DEADBEEF; RS0=1, RS1=5 -> o_DS = FEEDFACE, DEADBEEF next cycle.
REQ-036 SHALL cover Bypass=1: write x16=C0FFEEEE with RS0=16 same cycle -> o_DS[0]=C0FFEEEE that cycle; write x0=12345678 -> reads of x0 stay 0.
REQ-037 SHALL cover NumWritePorts=2, both ports write x7 (port0=11111111, port1=22222222) -> x7 reads 22222222.
REQ-038 SHALL cover i_Clear pulse in READY -> o_Ready low 32 cycles; write x3=AAAA5555 during sweep -> o_WriteDropped pulses, x3 reads 0 after.
REQ-039 SHALL cover i_Reset low at sweep counter 10 -> after release, sweep restarts and o_Ready rises exactly 32 cycles later.
